// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: records first hit of each cover point and drains
// each newly covered point once as an absolute index over a valid/ready stream.
module cover_toggle_collector #(
  parameter int unsigned WIDTH       = 130,
  parameter logic [63:0] COVER_INDEX = 64'd0,
  parameter int unsigned CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_index,
  input  logic             clear_req,
  output logic             clear_ack,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SEND, CLEAR} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] covered, sent, pending, fresh;
  logic [IW-1:0]    sel, lo;
  logic             found;
  logic [CNT_W-1:0] hits;

  // Both bitmaps are registered, so a point cannot be pending in its capture cycle.
  assign pending = covered & ~sent;
  assign fresh   = valid & ~covered;

  always_comb begin
    found = 1'b0;
    lo    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pending[i] && !found) begin
        found = 1'b1;
        lo    = IW'(i);
      end
    end
  end

  always_comb begin
    hits = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      hits = hits + CNT_W'(fresh[i]);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clear_req) state_nx = CLEAR;
               else if (found) state_nx = SEND;
      SEND:    if (out_ready) state_nx = IDLE;
      CLEAR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      covered       <= '0;
      sent          <= '0;
      sel           <= '0;
      out_index     <= '0;
      covered_count <= '0;
    end else begin
      state <= state_nx;
      if (state == CLEAR) begin
        covered       <= '0;
        sent          <= '0;
        covered_count <= '0;
      end else begin
        covered       <= covered | valid;
        covered_count <= covered_count + hits;
        if (state == IDLE && !clear_req && found) begin
          sel       <= lo;
          out_index <= COVER_INDEX + 64'(lo);
        end
        if (state == SEND && out_ready) sent[sel] <= 1'b1;
      end
    end
  end

  assign out_valid   = (state == SEND);
  assign clear_ack   = (state == CLEAR);
  assign all_covered = (covered_count == CNT_W'(WIDTH));

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector with an expected-index scoreboard.
module tb_cover_toggle_collector;

  localparam int unsigned WIDTH = 130;
  localparam logic [63:0] CI    = 64'd1000;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             out_ready = 1'b0;
  logic             clear_req = 1'b0;
  logic [WIDTH-1:0] valid = '0;
  logic             out_valid, clear_ack, all_covered;
  logic [63:0]      out_index;
  logic [CNT_W-1:0] covered_count;

  int unsigned total = 0, passed = 0, fails = 0, n_reports = 0, cyc = 0, r0 = 0;
  logic [63:0] exp_q[$];
  int unsigned hs_q[$];
  bit          random_mode = 1'b0;
  logic [WIDTH-1:0] seen = '0;

  cover_toggle_collector #(.WIDTH(WIDTH), .COVER_INDEX(CI), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .valid(valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .clear_req(clear_req), .clear_ack(clear_ack),
    .covered_count(covered_count), .all_covered(all_covered)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // A handshake seen at the falling edge completes on the following rising edge.
  always @(negedge clock) begin
    int unsigned k;
    if (reset && out_valid && out_ready) begin
      n_reports++;
      hs_q.push_back(cyc);
      if (random_mode) begin
        check("idx_range", 64'(out_index >= CI && out_index < CI + 64'(WIDTH)), 64'd1);
        if (out_index >= CI && out_index < CI + 64'(WIDTH)) begin
          k = 32'(out_index - CI);
          check("idx_unique", 64'(seen[k]), 64'd0);
          seen[k] = 1'b1;
        end
      end else begin
        check("report_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("out_index", out_index, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step(3);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count", 64'(covered_count), 64'd0);
    check("rst_all_covered", 64'(all_covered), 64'd0);
    check("rst_clear_ack", 64'(clear_ack), 64'd0);
    check("rst_out_index", out_index, 64'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    step();

    // single hit, latency
    r0 = n_reports;
    valid[5] = 1'b1;
    exp_q.push_back(CI + 64'd5);
    step();
    valid = '0;
    check("t1_count", 64'(covered_count), 64'd1);
    check("t1_valid_e0", 64'(out_valid), 64'd0);
    step();
    check("t1_valid_e1", 64'(out_valid), 64'd1);
    check("t1_index", out_index, CI + 64'd5);
    step();
    check("t1_valid_after", 64'(out_valid), 64'd0);
    step(3);
    check("t1_reports", 64'(n_reports - r0), 64'd1);

    // multi-bit hit, order and throughput
    hs_q.delete();
    valid[129] = 1'b1; valid[0] = 1'b1; valid[64] = 1'b1;
    exp_q.push_back(CI);
    exp_q.push_back(CI + 64'd64);
    exp_q.push_back(CI + 64'd129);
    step();
    valid = '0;
    check("t2_count", 64'(covered_count), 64'd4);
    step(8);
    check("t2_hs_count", 64'(hs_q.size()), 64'd3);
    if (hs_q.size() == 3) begin
      check("t2_gap0", 64'(hs_q[1] - hs_q[0]), 64'd2);
      check("t2_gap1", 64'(hs_q[2] - hs_q[1]), 64'd2);
    end

    // backpressure with repeated re-hits
    out_ready = 1'b0;
    r0 = n_reports;
    valid[7] = 1'b1;
    exp_q.push_back(CI + 64'd7);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_count", 64'(covered_count), 64'd5);
      if (i >= 1) begin
        check("t3_valid", 64'(out_valid), 64'd1);
        check("t3_index", out_index, CI + 64'd7);
      end
    end
    valid = '0;
    out_ready = 1'b1;
    step(4);
    check("t3_reports", 64'(n_reports - r0), 64'd1);

    // reset while presenting with points pending
    out_ready = 1'b0;
    valid[10] = 1'b1; valid[20] = 1'b1; valid[30] = 1'b1;
    step();
    valid = '0;
    step();
    check("t5_presenting", 64'(out_valid), 64'd1);
    reset = 1'b0;
    step();
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_count", 64'(covered_count), 64'd0);
    check("t5_index", out_index, 64'd0);
    reset = 1'b1;
    out_ready = 1'b1;
    r0 = n_reports;
    step(6);
    check("t5_no_reports", 64'(n_reports - r0), 64'd0);
    check("t5_valid_idle", 64'(out_valid), 64'd0);

    // cover every point with random hits and backpressure
    random_mode = 1'b1;
    seen = '0;
    r0 = n_reports;
    for (int c = 0; c < 300; c++) begin
      for (int b = 0; b < int'(WIDTH); b++) valid[b] = ($urandom_range(0, 63) == 0);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    valid = '1;
    step();
    valid = '0;
    check("t4_count", 64'(covered_count), 64'(WIDTH));
    check("t4_all_covered", 64'(all_covered), 64'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 400 && (n_reports - r0) < WIDTH; c++) step();
    step(4);
    check("t4_reports", 64'(n_reports - r0), 64'(WIDTH));
    check("t4_all_seen", 64'(&seen), 64'd1);
    check("t4_drained", 64'(out_valid), 64'd0);
    random_mode = 1'b0;

    // clear from IDLE, hit during CLEAR dropped
    out_ready = 1'b0;
    clear_req = 1'b1;
    step();
    check("t6_ack", 64'(clear_ack), 64'd1);
    clear_req = 1'b0;
    valid[9] = 1'b1;
    step();
    valid = '0;
    check("t6_ack_low", 64'(clear_ack), 64'd0);
    check("t6_count", 64'(covered_count), 64'd0);
    check("t6_all_covered", 64'(all_covered), 64'd0);
    step(3);
    check("t6_dropped", 64'(covered_count), 64'd0);
    check("t6_idle", 64'(out_valid), 64'd0);

    // clear requested during SEND waits for the handshake
    valid[3] = 1'b1;
    exp_q.push_back(CI + 64'd3);
    step();
    valid = '0;
    step();
    check("t7_send", 64'(out_valid), 64'd1);
    check("t7_index", out_index, CI + 64'd3);
    clear_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t7_no_ack", 64'(clear_ack), 64'd0);
      check("t7_held", 64'(out_valid), 64'd1);
      check("t7_count", 64'(covered_count), 64'd1);
    end
    out_ready = 1'b1;
    step();
    check("t7_hs_no_ack", 64'(clear_ack), 64'd0);
    check("t7_hs_idle", 64'(out_valid), 64'd0);
    step();
    check("t7_ack", 64'(clear_ack), 64'd1);
    clear_req = 1'b0;
    step();
    check("t7_ack_pulse", 64'(clear_ack), 64'd0);
    check("t7_cleared", 64'(covered_count), 64'd0);
    r0 = n_reports;
    valid[5] = 1'b1;
    exp_q.push_back(CI + 64'd5);
    step();
    valid = '0;
    step(4);
    check("t7_rereport", 64'(n_reports - r0), 64'd1);
    check("t7_count_new", 64'(covered_count), 64'd1);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
